scan_ctrl: RTL and testbench
============================

Name: scan_ctrl

Overview:
- Frame-level sequencer for the serpentine pixel-position counter that feeds the FAST corner pipeline.
- On a start command it latches the frame size, clears the position counter, then loops over every pixel: issue a pixel request over a valid/ready handshake, wait for the detector's result, advance the position.
- One request in flight at a time. Reports frame completion, a processed-pixel count, and timeout/config errors.
- Sits between the top-level control registers and the position counter / window-fetch front end.

Parameters:
- X_MAX, 5, maximum frame width; sets coordinate width XW = $clog2(X_MAX).
- Y_MAX, 5, maximum frame height; sets YW = $clog2(Y_MAX).
- TIMEOUT, 64, max cycles in WAIT_RES before abandoning the frame; TW = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  cancel current frame.
- cfg_width  in  XW  frame width, sampled with start.
- cfg_height  in  YW  frame height, sampled with start.
- pos_x  in  XW  current x from position counter.
- pos_y  in  YW  current y from position counter.
- pos_dir  in  2  next-direction code from position counter.
- pos_end  in  1  position counter at last pixel.
- pos_max_x  out  XW  latched width to position counter.
- pos_max_y  out  YW  latched height to position counter.
- pos_update  out  1  one-cycle advance pulse.
- pos_new_trans  out  1  one-cycle clear/new-frame pulse.
- req_valid  out  1  pixel request valid.
- req_ready  in  1  downstream accepts request.
- req_x  out  XW  requested x.
- req_y  out  YW  requested y.
- req_dir  out  2  direction hint.
- res_valid  in  1  detector finished current pixel.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame (normal, abort, or error).
- err  out  1  sticky error flag.
- pix_count  out  XW+YW+1  pixels completed this frame.

Behaviour:
- Reset: state IDLE. All outputs 0: pos_max_*, req_*, pix_count, err, busy, frame_done, pos_update, pos_new_trans. Watchdog counter 0.
- rst asserted mid-frame behaves identically; no partial request survives.
- States: IDLE, INIT, REQ, WAIT_RES, ADVANCE, DONE.
- IDLE:
  - start=1 with cfg_width==0 or cfg_height==0: set err=1, go DONE; no request is issued.
  - start=1 with both dims nonzero: latch dims into pos_max_*, clear err and pix_count, go INIT.
  - start while not IDLE is ignored.
- INIT: pos_new_trans=1 for exactly one cycle, then REQ.
- REQ:
  - req_valid=1; req_x/req_y/req_dir driven from pos_* and held stable until accepted.
  - Transfer happens on the cycle req_valid && req_ready; then go WAIT_RES and clear the watchdog.
  - Throughput is at most one request per 3 cycles.
- WAIT_RES:
  - req_valid=0; watchdog increments each cycle.
  - res_valid=1: pix_count+1. If pos_end=1 go DONE, else go ADVANCE.
  - Watchdog reaches TIMEOUT with no res_valid: err=1, go DONE. If res_valid arrives on that same cycle, res_valid wins.
- ADVANCE: pos_update=1 for exactly one cycle, then REQ. The new position is visible on pos_* in the REQ cycle.
- DONE: frame_done=1 for one cycle, then IDLE.
- abort=1 in INIT/REQ/WAIT_RES/ADVANCE: go DONE next cycle with req_valid dropped immediately. Abort beats req_ready, res_valid and timeout on the same cycle; pix_count is not incremented. abort in IDLE or DONE is ignored.
- res_valid outside WAIT_RES is ignored. req_ready outside REQ is ignored.
- pos_max_* hold their value after the frame until the next accepted start.
- Frame of width 1 / height 1 yields exactly one request, then DONE.

Test Plan:
- 2x2 frame, req_ready=1, res_valid 2 cycles after each transfer, with the real position counter attached -> requests (0,0),(1,0),(1,1),(0,1) in order; single frame_done pulse; pix_count=4; err=0; busy falls the cycle after frame_done.
- Backpressure: hold req_ready=0 for 3 cycles on the second request -> req_valid stays 1 and req_x/req_y/req_dir are constant across all stalled cycles; exactly 4 transfers in total.
- Timeout, TIMEOUT=8: withhold res_valid on the first request -> err=1 after 8 WAIT_RES cycles; frame_done pulses; pix_count=0. Boundary case: res_valid on the 8th cycle -> no error.
- Abort: assert abort together with req_ready on the third request of a 3x3 frame -> no transfer counted; frame_done next cycle; pix_count=2; err=0.
- Config/start: start with cfg_width=0 -> err=1 and frame_done with no req_valid. Start pulsed while busy -> ignored, frame unaffected. Next valid start clears err.
- Reset mid-frame: assert rst in WAIT_RES -> next cycle all outputs 0 and state IDLE; a subsequent 1x1 frame gives one request at (0,0) and pix_count=1.

Source files
------------

// File: rtl/scan_ctrl.sv
// Frame sequencer for the serpentine position counter: one pixel request in flight, waits for the detector result.
// A request is held stable on req_* until req_ready; abort, config and watchdog errors all end the frame via DONE.
module scan_ctrl #(
  parameter int X_MAX   = 5,
  parameter int Y_MAX   = 5,
  parameter int TIMEOUT = 64,
  localparam int XW = $clog2(X_MAX),
  localparam int YW = $clog2(Y_MAX),
  localparam int TW = $clog2(TIMEOUT + 1),
  localparam int PW = XW + YW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] cfg_width,
  input  logic [YW-1:0] cfg_height,
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  input  logic [1:0]    pos_dir,
  input  logic          pos_end,
  output logic [XW-1:0] pos_max_x,
  output logic [YW-1:0] pos_max_y,
  output logic          pos_update,
  output logic          pos_new_trans,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  output logic [1:0]    req_dir,
  input  logic          res_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          err,
  output logic [PW-1:0] pix_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_REQ, S_WAIT, S_ADV, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] max_x_q, max_x_d;
  logic [YW-1:0] max_y_q, max_y_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          cfg_bad;
  logic          wdog_expired;

  assign cfg_bad      = (cfg_width == '0) || (cfg_height == '0);
  // The TIMEOUT-th WAIT cycle is the last one in which a result is still accepted.
  assign wdog_expired = (wdog_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      max_x_q <= '0;
      max_y_q <= '0;
      pix_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      pix_q   <= pix_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    pix_d   = pix_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            max_x_d = cfg_width;
            max_y_d = cfg_height;
            err_d   = 1'b0;
            pix_d   = '0;
            state_d = S_INIT;
          end
        end
      end
      S_INIT: state_d = abort ? S_DONE : S_REQ;
      S_REQ: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (req_ready) begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Abort outranks a same-cycle result, which in turn outranks the watchdog.
        if (abort) begin
          state_d = S_DONE;
        end else if (res_valid) begin
          pix_d   = pix_q + PW'(1);
          state_d = pos_end ? S_DONE : S_ADV;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      S_ADV:   state_d = abort ? S_DONE : S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid     = 1'b0;
    req_x         = '0;
    req_y         = '0;
    req_dir       = '0;
    pos_update    = (state_q == S_ADV);
    pos_new_trans = (state_q == S_INIT);
    frame_done    = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
    if (state_q == S_REQ) begin
      req_valid = !abort;
      req_x     = pos_x;
      req_y     = pos_y;
      req_dir   = pos_dir;
    end
  end

  assign pos_max_x = max_x_q;
  assign pos_max_y = max_y_q;
  assign err       = err_q;
  assign pix_count = pix_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with a serpentine position counter and a scripted downstream/detector.
module tb_scan_ctrl;
  localparam int X_MAX = 5, Y_MAX = 5, TIMEOUT = 8;
  localparam int XW = 3, YW = 3, PW = 7;

  logic clk = 1'b0;
  logic rst, start, abort, req_ready, res_valid;
  logic [XW-1:0] cfg_width, pos_x, pos_max_x, req_x;
  logic [YW-1:0] cfg_height, pos_y, pos_max_y, req_y;
  logic [1:0] pos_dir, req_dir;
  logic pos_end, pos_update, pos_new_trans, req_valid, busy, frame_done, err;
  logic [PW-1:0] pix_count;
  logic [26:0] all_out;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  scan_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pos_x(pos_x), .pos_y(pos_y), .pos_dir(pos_dir), .pos_end(pos_end),
    .pos_max_x(pos_max_x), .pos_max_y(pos_max_y),
    .pos_update(pos_update), .pos_new_trans(pos_new_trans),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_dir(req_dir),
    .res_valid(res_valid), .busy(busy), .frame_done(frame_done),
    .err(err), .pix_count(pix_count)
  );

  assign all_out = {pos_max_x, pos_max_y, pos_update, pos_new_trans, req_valid,
                    req_x, req_y, req_dir, busy, frame_done, err, pix_count};

  // Serpentine position counter: even rows run +x, odd rows run -x; dir 0=+x, 1=-x, 2=+y.
  logic row_end;
  assign row_end = pos_y[0] ? (pos_x == 3'd0) : (pos_x == pos_max_x - 3'd1);
  assign pos_end = row_end && (pos_y == pos_max_y - 3'd1);
  assign pos_dir = row_end ? 2'd2 : (pos_y[0] ? 2'd1 : 2'd0);

  always @(posedge clk) begin
    if (rst || pos_new_trans) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (pos_update) begin
      if (row_end) pos_y <= pos_y + 3'd1;
      else if (pos_y[0]) pos_x <= pos_x - 3'd1;
      else pos_x <= pos_x + 3'd1;
    end
  end

  // Per-frame observations
  int n_xfer, n_done, n_rv, stall_bad, abort_bad, done_cyc, xfer_cyc, abort_cyc, done_pix;
  logic done_err, busy_after, done_after, err_after;
  logic [XW-1:0] rx [16];
  logic [YW-1:0] ry [16];
  logic [1:0]    rd [16];

  task automatic run_frame(input int w, input int h, input int stall_at, input int stall_len,
                           input int res_dly, input int abort_at, input int start_mid_cyc);
    int stall_left, wcnt;
    bit in_wait, expect_req, stalled, aborted;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [1:0] hd;
    n_xfer = 0; n_done = 0; n_rv = 0; stall_bad = 0; abort_bad = 0;
    done_cyc = -1; xfer_cyc = -1; abort_cyc = -1; done_pix = -1; done_err = 1'bx;
    stall_left = stall_len; wcnt = 0;
    in_wait = 0; expect_req = 0; stalled = 0; aborted = 0;
    hx = '0; hy = '0; hd = '0;
    @(posedge clk); #1;
    cfg_width = XW'(w); cfg_height = YW'(h); start = 1'b1;
    abort = 1'b0; res_valid = 1'b0; req_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start = (cyc == start_mid_cyc);
        cfg_width = '0; cfg_height = '0;
        if (in_wait) wcnt++;
        res_valid = in_wait && (wcnt == res_dly);
        req_ready = !(n_xfer == stall_at && stall_left > 0);
        abort = expect_req && (n_xfer == abort_at) && !aborted;
      end
      #1;
      expect_req = pos_new_trans || pos_update;
      if (abort) begin
        aborted = 1; abort_cyc = cyc; in_wait = 0;
        if (req_valid !== 1'b0) abort_bad++;
      end
      if (req_valid === 1'b1) begin
        n_rv++;
        if (stalled && (req_x !== hx || req_y !== hy || req_dir !== hd)) stall_bad++;
        if (req_ready) begin
          if (n_xfer < 16) begin
            rx[n_xfer] = req_x; ry[n_xfer] = req_y; rd[n_xfer] = req_dir;
          end
          n_xfer++; in_wait = 1; wcnt = 0; stalled = 0; xfer_cyc = cyc;
        end else begin
          stalled = 1; hx = req_x; hy = req_y; hd = req_dir; stall_left--;
        end
      end
      if (res_valid) in_wait = 0;
      if (frame_done === 1'b1) begin
        n_done++; done_cyc = cyc; done_pix = int'(pix_count); done_err = err;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; res_valid = 1'b0; req_ready = 1'b0;
    #1;
    busy_after = busy; done_after = frame_done; err_after = err;
    n_tests++;
    if (n_done == 0) begin
      n_fail++;
      $display("FAIL frame_done_wait: no frame_done within 200 cycles (w=%0d h=%0d)", w, h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; req_ready = 1'b0; res_valid = 1'b0;
    cfg_width = '0; cfg_height = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (all_out !== 27'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst = 1'b0;
  endtask

  task automatic test_frame_2x2();
    logic [7:0] exp_req [4];
    exp_req[0] = {3'd0, 3'd0, 2'd0};
    exp_req[1] = {3'd1, 3'd0, 2'd2};
    exp_req[2] = {3'd1, 3'd1, 2'd1};
    exp_req[3] = {3'd0, 3'd1, 2'd2};
    run_frame(2, 2, -1, 0, 2, -1, -1);
    n_tests++;
    if (n_xfer !== 4) begin n_fail++; $display("FAIL f2x2_xfers: got %0d expected 4", n_xfer); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({rx[i], ry[i], rd[i]} !== exp_req[i]) begin
        n_fail++;
        $display("FAIL f2x2_req%0d: got x=%0d y=%0d d=%0d expected {x,y,d}=%h", i, rx[i], ry[i], rd[i], exp_req[i]);
      end
    end
    n_tests++;
    if (n_done !== 1 || done_after !== 1'b0) begin n_fail++; $display("FAIL f2x2_done_pulse: got %0d/%b expected 1/0", n_done, done_after); end
    n_tests++;
    if (done_pix !== 4) begin n_fail++; $display("FAIL f2x2_pix: got %0d expected 4", done_pix); end
    n_tests++;
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL f2x2_err: got %b expected 0", done_err); end
    n_tests++;
    if (done_cyc !== 17) begin n_fail++; $display("FAIL f2x2_latency: got %0d expected 17", done_cyc); end
    n_tests++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL f2x2_busy_after: got %b expected 0", busy_after); end
    n_tests++;
    if (pos_max_x !== 3'd2 || pos_max_y !== 3'd2) begin n_fail++; $display("FAIL f2x2_pos_max: got %0d,%0d expected 2,2", pos_max_x, pos_max_y); end
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 1, 3, 2, -1, -1);
    n_tests++;
    if (n_rv !== 7) begin n_fail++; $display("FAIL bp_valid_cycles: got %0d expected 7", n_rv); end
    n_tests++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_bad); end
    n_tests++;
    if (n_xfer !== 4) begin n_fail++; $display("FAIL bp_xfers: got %0d expected 4", n_xfer); end
    n_tests++;
    if (done_cyc !== 20) begin n_fail++; $display("FAIL bp_latency: got %0d expected 20", done_cyc); end
  endtask

  task automatic test_timeout();
    run_frame(2, 2, -1, 0, 0, -1, -1);
    n_tests++;
    if (n_xfer !== 1) begin n_fail++; $display("FAIL tmo_xfers: got %0d expected 1", n_xfer); end
    n_tests++;
    if (done_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", done_err); end
    n_tests++;
    if (done_pix !== 0) begin n_fail++; $display("FAIL tmo_pix: got %0d expected 0", done_pix); end
    n_tests++;
    if (done_cyc - xfer_cyc !== 9) begin n_fail++; $display("FAIL tmo_wait_cycles: got %0d expected 9", done_cyc - xfer_cyc); end
    run_frame(2, 2, -1, 0, 8, -1, -1);
    n_tests++;
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL tmo_boundary_err: got %b expected 0", done_err); end
    n_tests++;
    if (done_pix !== 4) begin n_fail++; $display("FAIL tmo_boundary_pix: got %0d expected 4", done_pix); end
  endtask

  task automatic test_abort();
    run_frame(3, 3, -1, 0, 2, 2, -1);
    n_tests++;
    if (n_xfer !== 2) begin n_fail++; $display("FAIL abort_xfers: got %0d expected 2", n_xfer); end
    n_tests++;
    if (abort_cyc !== 10 || done_cyc !== 11) begin n_fail++; $display("FAIL abort_timing: got abort@%0d done@%0d expected 10/11", abort_cyc, done_cyc); end
    n_tests++;
    if (abort_bad !== 0) begin n_fail++; $display("FAIL abort_req_valid: got %0d cycles high expected 0", abort_bad); end
    n_tests++;
    if (done_pix !== 2 || done_err !== 1'b0) begin n_fail++; $display("FAIL abort_pix_err: got %0d/%b expected 2/0", done_pix, done_err); end
  endtask

  task automatic test_config_error();
    run_frame(0, 2, -1, 0, 2, -1, -1);
    n_tests++;
    if (n_rv !== 0) begin n_fail++; $display("FAIL cfg_no_req: got %0d valid cycles expected 0", n_rv); end
    n_tests++;
    if (done_err !== 1'b1 || done_cyc !== 1) begin n_fail++; $display("FAIL cfg_err_done: got err=%b done@%0d expected 1/1", done_err, done_cyc); end
    n_tests++;
    if (err_after !== 1'b1) begin n_fail++; $display("FAIL cfg_err_sticky: got %b expected 1", err_after); end
    n_tests++;
    if (pos_max_x !== 3'd3 || pos_max_y !== 3'd3) begin n_fail++; $display("FAIL cfg_pos_max_hold: got %0d,%0d expected 3,3", pos_max_x, pos_max_y); end
  endtask

  task automatic test_start_while_busy();
    run_frame(2, 2, -1, 0, 2, -1, 7);
    n_tests++;
    if (n_xfer !== 4 || n_done !== 1) begin n_fail++; $display("FAIL busy_start_frame: got %0d xfers %0d dones expected 4/1", n_xfer, n_done); end
    n_tests++;
    if (done_err !== 1'b0) begin n_fail++; $display("FAIL busy_start_err_clear: got %b expected 0", done_err); end
    n_tests++;
    if (done_pix !== 4 || done_cyc !== 17) begin n_fail++; $display("FAIL busy_start_pix: got %0d@%0d expected 4@17", done_pix, done_cyc); end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    cfg_width = 3'd2; cfg_height = 3'd2; start = 1'b1; req_ready = 1'b1; res_valid = 1'b0; abort = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (all_out !== 27'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", all_out); end
    run_frame(1, 1, -1, 0, 2, -1, -1);
    n_tests++;
    if (n_xfer !== 1 || rx[0] !== 3'd0 || ry[0] !== 3'd0) begin n_fail++; $display("FAIL rst_1x1_req: got %0d xfers at (%0d,%0d) expected 1 at (0,0)", n_xfer, rx[0], ry[0]); end
    n_tests++;
    if (done_pix !== 1 || done_cyc !== 5) begin n_fail++; $display("FAIL rst_1x1_pix: got %0d@%0d expected 1@5", done_pix, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_frame_2x2();
    test_backpressure();
    test_timeout();
    test_abort();
    test_config_error();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
